// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: turns byte/half/word CPU requests into word-aligned memory accesses with byte lanes.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned requests instead of truncating them.
module lsu_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          unsigned_q;
  logic          write_q;

  logic [1:0]    eff_off;
  logic          illegal;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic          timeout_hit;

  assign req_ready   = (state == IDLE);
  assign stall       = ((state == IDLE) && req_valid) || (state == ACCESS);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    eff_off    = 2'b00;
    lane_we    = 4'b0000;
    lane_wdata = req_wdata;
    illegal    = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      illegal = 1'b1;
`endif
    // Misaligned half/word addresses are truncated to their natural granularity.
    case (req_size)
      2'b00: begin
        eff_off    = req_addr[1:0];
        lane_we    = 4'b0001 << eff_off;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        eff_off    = {req_addr[1], 1'b0};
        lane_we    = 4'b0011 << eff_off;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'b10:   lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
  end

  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00: load_data = unsigned_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = unsigned_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q      <= eff_off;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            write_q    <= req_write;
            cnt        <= '0;
            if (illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_write ? lane_we : 4'b0000;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= lane_wdata;
            end
          end
        end
        ACCESS: begin
          // An ack in the final timeout cycle still completes the access normally.
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= write_q ? 32'd0 : load_data;
          end else if (timeout_hit) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed, table-driven bench for lsu_mem_bridge; expected values are hand-computed.
module tb_lsu_mem_bridge;

  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lsu_mem_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_wait;
    logic [3:0]  we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        err;
    logic [31:0] rdata_exp;
    int          acc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   n_acc;
    int   cyc;
    bit   got;
    bit   first;
    v     = vecs[i];
    n_acc = 0;
    cyc   = 0;
    got   = 1'b0;
    first = 1'b1;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    mem_ack      = 1'b0;
    #1;
    check($sformatf("v%0d stall_req", i), 32'(stall), 32'd1);
    check($sformatf("v%0d ready_idle", i), 32'(req_ready), 32'd1);
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      if (rsp_valid) begin
        got = 1'b1;
      end else if (mem_req) begin
        if (first) begin
          check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.we));
          check($sformatf("v%0d mem_addr", i), mem_addr, v.maddr);
          check($sformatf("v%0d mem_wdata", i), mem_wdata, v.mwdata);
          check($sformatf("v%0d stall_access", i), 32'(stall), 32'd1);
          first = 1'b0;
        end
        if (n_acc == v.ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        n_acc++;
      end
    end
    check($sformatf("v%0d got_rsp", i), 32'(got), 32'd1);
    if (got) begin
      check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(v.err));
      check($sformatf("v%0d rsp_rdata", i), rsp_rdata, v.rdata_exp);
      check($sformatf("v%0d stall_resp", i), 32'(stall), 32'd0);
      check($sformatf("v%0d ready_resp", i), 32'(req_ready), 32'd0);
      check($sformatf("v%0d mem_req_resp", i), 32'(mem_req), 32'd0);
      check($sformatf("v%0d access_cycles", i), 32'(n_acc), 32'(v.acc));
      check($sformatf("v%0d latency", i), 32'(cyc), 32'(v.acc + 1));
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("v%0d rsp_valid_after", i), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d rsp_err_after", i), 32'(rsp_err), 32'd0);
    check($sformatf("v%0d rsp_rdata_after", i), rsp_rdata, 32'd0);
    check($sformatf("v%0d ready_after", i), 32'(req_ready), 32'd1);
  endtask

  initial begin
    //         wr    size   uns   addr          wdata         rdata         ack    we       maddr         mwdata        err   rdata_exp     acc
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h0,        2,     4'b1111, 32'h00000100, 32'hDEADBEEF, 1'b0, 32'h00000000, 3};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h00000103, 32'h0,        32'h80000000, 0,     4'b0000, 32'h00000100, 32'h00000000, 1'b0, 32'hFFFFFF80, 1};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h00000103, 32'h0,        32'h80000000, 0,     4'b0000, 32'h00000100, 32'h00000000, 1'b0, 32'h00000080, 1};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h00000202, 32'h00001234, 32'h0,        1,     4'b1100, 32'h00000200, 32'h12341234, 1'b0, 32'h00000000, 2};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h00000002, 32'h0,        32'h80017F00, 0,     4'b0000, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFF8001, 1};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h00000000, 32'h0,        32'h1234ABCD, 3,     4'b0000, 32'h00000000, 32'h00000000, 1'b0, 32'h0000ABCD, 4};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h00000201, 32'h000055AA, 32'h0,        0,     4'b0010, 32'h00000200, 32'hAAAAAAAA, 1'b0, 32'h00000000, 1};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0,        32'hCAFEF00D, 0,     4'b0000, 32'h00000300, 32'h00000000, 1'b0, 32'hCAFEF00D, 1};
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h00000001, 32'h0,        32'h00007F00, 0,     4'b0000, 32'h00000000, 32'h00000000, 1'b0, 32'h0000007F, 1};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h00000400, 32'h0,        32'h0,        NEVER, 4'b0000, 32'h00000400, 32'h00000000, 1'b1, 32'h00000000, 16};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h00000500, 32'h0,        32'h0,        0,     4'b0000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h00000600, 32'h0,        32'h0BADF00D, 15,    4'b0000, 32'h00000600, 32'h00000000, 1'b0, 32'h0BADF00D, 16};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h00000101, 32'h0,        32'h11223344, 0,     4'b0000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h00000203, 32'h0000BEEF, 32'h0,        0,     4'b0000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 0};
`else
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h00000101, 32'h0,        32'h11223344, 0,     4'b0000, 32'h00000100, 32'h00000000, 1'b0, 32'h11223344, 1};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h00000203, 32'h0000BEEF, 32'h0,        0,     4'b1100, 32'h00000200, 32'hBEEFBEEF, 1'b0, 32'h00000000, 1};
`endif

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset stall", 32'(stall), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i);

    // Reset in the middle of an access: request dropped, no response afterwards.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h00000700;
    repeat (2) @(posedge clk);
    #1;
    check("midrst mem_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst mem_req", 32'(mem_req), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    check("midrst stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst quiet%0d rsp_valid", k), 32'(rsp_valid), 32'd0);
      check($sformatf("midrst quiet%0d mem_req", k), 32'(mem_req), 32'd0);
    end

    // Back-to-back use after the aborted access still works.
    run_vec(7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
